// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the RS syndrome block: field constants, byte type,
// FSM state encoding and the constant multiply-by-alpha^j helper.
package rs_pkg;

    localparam int          RS_N    = 200;
    localparam int          RS_NSYM = 32;
    localparam logic [8:0]  GF_POLY = 9'h11D;

    typedef logic [7:0] gf8_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic gf8_t gf_xtime(input gf8_t a);
        gf8_t r;
        r = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
        return r;
    endfunction

    // With j constant this flattens to a pure XOR network (no clocked steps).
    function automatic gf8_t gf_mul_alpha_pow(input gf8_t a, input int j);
        gf8_t r;
        int   jj;
        r  = a;
        jj = j % 255;
        for (int k = 0; k < 255; k++) begin
            if (k < jj) begin
                r = gf_xtime(r);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_synd_lane.sv
// One Horner accumulator S <= S*alpha^J ^ d; exposes its next value so the top
// can register the error flag in the same cycle the last byte lands.
module rs_synd_lane
    import rs_pkg::*;
#(
    parameter int J = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic i_en,
    input  logic i_restart,
    input  gf8_t i_dat,
    output gf8_t o_synd,
    output gf8_t o_synd_nxt
);

    gf8_t r_synd;
    gf8_t w_horner;

    assign w_horner   = gf_mul_alpha_pow(r_synd, J) ^ i_dat;
    assign o_synd_nxt = !i_en ? r_synd : (i_restart ? i_dat : w_horner);
    assign o_synd     = r_synd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_synd <= '0;
        end else if (clr_i) begin
            r_synd <= '0;
        end else begin
            r_synd <= o_synd_nxt;
        end
    end

endmodule

// File: rtl/rs_syndrome.sv
// RS syndrome calculator: one byte per cycle, result held in DONE until consumed;
// input stalls (ready low) while a result is held. Optional RS_SYNDROME_ERRCNT_EN adds err_cnt_o.
module rs_syndrome
    import rs_pkg::*;
#(
    parameter int N    = RS_N,
    parameter int NSYM = RS_NSYM
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                cw_valid_i,
    output logic                cw_ready_o,
    input  logic [7:0]          cw_data_i,
    output logic                synd_valid_o,
    input  logic                synd_ready_i,
    output logic [8*NSYM-1:0]   synd_o,
    output logic                err_o
`ifdef RS_SYNDROME_ERRCNT_EN
    ,
    output logic [15:0]         err_cnt_o
`endif
);

    localparam int              CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic               r_err;
    logic               w_accept;
    logic               w_restart;
    logic               w_last;
    logic               w_done_exit;
    logic [8*NSYM-1:0]  w_synd_nxt;

    // Ready is gated by clr so a clear never coincides with a handshake.
    assign cw_ready_o   = rst_ni && !clr_i && (r_state != ST_DONE);
    assign w_accept     = cw_valid_i && cw_ready_o;
    assign w_restart    = (r_state == ST_IDLE);
    assign w_last       = (r_state == ST_IDLE) ? (N == 1) : (r_count == LAST);
    assign w_done_exit  = (r_state == ST_DONE) && synd_ready_i;
    assign synd_valid_o = (r_state == ST_DONE);
    assign err_o        = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (synd_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clr_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_count <= w_last ? '0 : (w_restart ? CW'(1) : r_count + 1'b1);
            end
            // Flag is taken from the lanes' next values so it is valid on DONE entry.
            if (w_accept && w_last) begin
                r_err <= |w_synd_nxt;
            end else if (w_done_exit) begin
                r_err <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NSYM; g++) begin : g_lane
        rs_synd_lane #(
            .J (g)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_i      (clr_i),
            .i_en       (w_accept),
            .i_restart  (w_restart),
            .i_dat      (cw_data_i),
            .o_synd     (synd_o[8*g +: 8]),
            .o_synd_nxt (w_synd_nxt[8*g +: 8])
        );
    end

`ifdef RS_SYNDROME_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (clr_i) begin
            r_err_cnt <= '0;
        end else if (w_done_exit && r_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// Randomized scoreboard bench for rs_syndrome against a direct polynomial-evaluation model
// and a software RS(200,168) encoder.
module tb_rs_syndrome;

    localparam int N    = 200;
    localparam int NSYM = 32;
    localparam int K    = N - NSYM;

    logic               clk_i        = 1'b0;
    logic               rst_ni       = 1'b0;
    logic               clr_i        = 1'b0;
    logic               cw_valid_i   = 1'b0;
    logic [7:0]         cw_data_i    = 8'h00;
    logic               synd_ready_i = 1'b0;
    logic               cw_ready_o;
    logic               synd_valid_o;
    logic [8*NSYM-1:0]  synd_o;
    logic               err_o;
`ifdef RS_SYNDROME_ERRCNT_EN
    logic [15:0]        err_cnt_o;
`endif

    rs_syndrome #(.N(N), .NSYM(NSYM)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .cw_valid_i   (cw_valid_i),
        .cw_ready_o   (cw_ready_o),
        .cw_data_i    (cw_data_i),
        .synd_valid_o (synd_valid_o),
        .synd_ready_i (synd_ready_i),
        .synd_o       (synd_o),
        .err_o        (err_o)
`ifdef RS_SYNDROME_ERRCNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8*NSYM-1:0] synd;
        logic              err;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               mon_e;
    logic [7:0]         cw_buf  [N];
    logic [7:0]         exp_tbl [255];
    logic [7:0]         gen     [NSYM+1];
    int                 n_checks   = 0;
    int                 n_errors   = 0;
    int                 hold_req   = -1;
    int                 cur_hold   = 0;
    int                 done_cnt   = 0;
    int                 exp_errcnt = 0;
    logic               prev_valid = 1'b0;
    logic [8*NSYM-1:0]  held       = '0;
    logic               held_err   = 1'b0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
        return p[7:0];
    endfunction

    // Direct evaluation: S_j = sum_i c_i * alpha^(j*(N-1-i)).
    function automatic exp_t model();
        exp_t r;
        r.synd = '0;
        for (int j = 0; j < NSYM; j++)
            for (int i = 0; i < N; i++)
                r.synd[8*j +: 8] = r.synd[8*j +: 8] ^ gmul(cw_buf[i], exp_tbl[(j * (N - 1 - i)) % 255]);
        r.err = |r.synd;
        return r;
    endfunction

    task automatic build_gen();
        logic [7:0] g  [NSYM+1];
        logic [7:0] nw [NSYM+1];
        int len;
        for (int k = 0; k <= NSYM; k++) g[k] = 8'h00;
        g[0] = 8'h01;
        len  = 1;
        for (int j = 0; j < NSYM; j++) begin
            for (int k = 0; k <= NSYM; k++) begin
                nw[k] = 8'h00;
                if (k < len) nw[k] = g[k];
                if (k > 0 && k <= len) nw[k] = nw[k] ^ gmul(exp_tbl[j], g[k-1]);
            end
            len++;
            for (int k = 0; k <= NSYM; k++) g[k] = nw[k];
        end
        for (int k = 0; k <= NSYM; k++) gen[k] = g[k];
    endtask

    task automatic encode_random();
        logic [7:0] rem [NSYM];
        logic [7:0] fb;
        for (int k = 0; k < NSYM; k++) rem[k] = 8'h00;
        for (int i = 0; i < K; i++) begin
            cw_buf[i] = 8'($urandom);
            fb = cw_buf[i] ^ rem[0];
            for (int k = 0; k < NSYM - 1; k++) rem[k] = rem[k+1] ^ gmul(fb, gen[k+1]);
            rem[NSYM-1] = gmul(fb, gen[NSYM]);
        end
        for (int k = 0; k < NSYM; k++) cw_buf[K + k] = rem[k];
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) cw_buf[i] = 8'($urandom);
    endtask

    task automatic abort(input string name);
        n_errors++;
        $display("FAIL %s: got timeout expected progress", name);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "bench aborted");
    endtask

    task automatic send_buf(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int waitc;
            hs    = 1'b0;
            waitc = 0;
            while (!hs) begin
                @(negedge clk_i);
                cw_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                cw_data_i  = cw_buf[i];
                #1;
                hs = cw_valid_i && cw_ready_o;
                @(posedge clk_i);
                waitc++;
                if (waitc > 5000) abort("input_handshake");
            end
        end
        @(negedge clk_i);
        cw_valid_i = 1'b0;
        if (n == N) chk("valid_latency", 256'(synd_valid_o), 256'(1));
    endtask

    task automatic send_full(input bit gaps);
        exp_q.push_back(model());
        send_buf(N, gaps);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (exp_q.size() != 0 || synd_valid_o) begin
            @(negedge clk_i);
            c++;
            if (c > 1000) abort("drain");
        end
        @(negedge clk_i);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 256'(cw_ready_o), 256'(0));
        chk({tag, "_valid"}, 256'(synd_valid_o), 256'(0));
        chk({tag, "_err"},   256'(err_o), 256'(0));
        chk({tag, "_synd"},  256'(synd_o), 256'(0));
`ifdef RS_SYNDROME_ERRCNT_EN
        chk({tag, "_errcnt"}, 256'(err_cnt_o), 256'(0));
`endif
    endtask

    // Monitor and consumer: compares each new result, then checks it holds while stalled.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_valid   = 1'b0;
            synd_ready_i = 1'b0;
        end else begin
            if (synd_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got valid expected none");
                    held     = synd_o;
                    held_err = err_o;
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("syndromes", 256'(synd_o), 256'(mon_e.synd));
                    chk("err_flag",  256'(err_o),  256'(mon_e.err));
                    held     = mon_e.synd;
                    held_err = mon_e.err;
                end
                done_cnt = 0;
                cur_hold = (hold_req < 0) ? int'($urandom_range(0, 3)) : hold_req;
            end else if (synd_valid_o) begin
                chk("synd_hold",     256'(synd_o),     256'(held));
                chk("err_hold",      256'(err_o),      256'(held_err));
                chk("ready_in_done", 256'(cw_ready_o), 256'(0));
            end else if (prev_valid) begin
                chk("idle_after_done", 256'(cw_ready_o), 256'(1));
                if (held_err && exp_errcnt < 65535) exp_errcnt++;
            end
            if (synd_valid_o) begin
                synd_ready_i = (done_cnt >= cur_hold);
                done_cnt++;
            end else begin
                synd_ready_i = 1'b0;
            end
            prev_valid = synd_valid_o;
        end
    end

    initial begin
        logic [7:0] e;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_tbl[i] = e;
            e = gmul(e, 8'h02);
        end
        build_gen();

        #2;
        check_reset_values("reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ready_after_reset", 256'(cw_ready_o), 256'(1));

        for (int i = 0; i < N; i++) cw_buf[i] = 8'h00;
        send_full(1'b0);
        cw_buf[N-1] = 8'h01;
        send_full(1'b0);
        cw_buf[N-1] = 8'h00;
        cw_buf[0]   = 8'h01;
        send_full(1'b0);

        for (int r = 0; r < 3; r++) begin
            encode_random();
            send_full(1'b1);
        end

        wait_idle();
        hold_req = 50;
        fill_random();
        send_full(1'b0);
        wait_idle();
        hold_req = -1;
        encode_random();
        send_full(1'b0);

        wait_idle();
        fill_random();
        send_buf(100, 1'b1);
        @(negedge clk_i);
        clr_i      = 1'b1;
        cw_valid_i = 1'b1;
        #1;
        chk("ready_during_clr", 256'(cw_ready_o), 256'(0));
        @(negedge clk_i);
        clr_i      = 1'b0;
        cw_valid_i = 1'b0;
        #1;
        chk("clr_valid", 256'(synd_valid_o), 256'(0));
        chk("clr_err",   256'(err_o), 256'(0));
        chk("clr_synd",  256'(synd_o), 256'(0));
        chk("clr_ready", 256'(cw_ready_o), 256'(1));
`ifdef RS_SYNDROME_ERRCNT_EN
        chk("clr_errcnt", 256'(err_cnt_o), 256'(0));
`endif
        exp_errcnt = 0;
        fill_random();
        send_full(1'b1);

        wait_idle();
        fill_random();
        send_buf(57, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_errcnt = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ready_after_midreset", 256'(cw_ready_o), 256'(1));
        fill_random();
        send_full(1'b1);
        encode_random();
        send_full(1'b1);
        fill_random();
        send_full(1'b0);

        wait_idle();
        chk("queue_drained", 256'(exp_q.size()), 256'(0));
`ifdef RS_SYNDROME_ERRCNT_EN
        chk("err_cnt", 256'(err_cnt_o), 256'(exp_errcnt));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rs_syndrome.md
RS_SYNDROME -- requirements
Module: rs_syndrome

Interface
REQ-001 Parameter N, default 200: codeword length in bytes.
REQ-002 Parameter NSYM, default 32: number of parity bytes and of syndromes.
REQ-003 Port clk_i, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port clr_i, input, 1: synchronous soft clear, same effect as reset.
REQ-006 Port cw_valid_i, input, 1: received codeword byte present.
REQ-007 Port cw_ready_o, output, 1: block accepts a byte.
REQ-008 Port cw_data_i, input, 8: codeword byte, highest-degree coefficient first.
REQ-009 Port synd_valid_o, output, 1: syndrome result held.
REQ-010 Port synd_ready_i, input, 1: consumer takes the result.
REQ-011 Port synd_o, output, 8*NSYM: S_j in bits [8j+7:8j].
REQ-012 Port err_o, output, 1: at least one S_j is nonzero; qualified by synd_valid_o.

Function
REQ-013 Arithmetic SHALL be GF(2^8) with primitive polynomial 0x11D; syndrome j evaluates at alpha^j, j=0..NSYM-1 (first consecutive root 0).
REQ-014 Horner update per accepted byte SHALL be S_j <= S_j*alpha^j XOR cw_data_i, using constant multipliers with no multi-cycle paths.
REQ-015 FSM states SHALL be IDLE, ACCUM, DONE; reset and clr_i enter IDLE.
REQ-016 IDLE: cw_ready_o=1; on the first accepted byte, S_j <= cw_data_i (accumulators restart), count <= 1, go to ACCUM.
REQ-017 ACCUM: cw_ready_o=1; each accepted byte increments count; the byte with count==N-1 moves to DONE.
REQ-018 DONE: cw_ready_o=0, synd_valid_o=1, synd_o and err_o stable; synd_valid_o rises the cycle after the Nth byte handshake.
REQ-019 DONE exits to IDLE when synd_ready_i=1; no input byte is accepted in that cycle.
REQ-020 A cycle with cw_valid_i=0 SHALL leave all state unchanged.
REQ-021 clr_i SHALL win over any simultaneous handshake; a partial codeword is discarded.
REQ-022 The byte counter SHALL be $clog2(N) bits wide and must not wrap within a codeword.

Reset
REQ-023 During reset: FSM=IDLE, count=0, all S_j=0, cw_ready_o=0, synd_valid_o=0, err_o=0, synd_o=0.
REQ-024 cw_ready_o SHALL assert in the first cycle after rst_ni deasserts.

Configuration
REQ-025 With RS_SYNDROME_ERRCNT_EN defined, the block SHALL add the output err_cnt_o[15:0], reset 0, cleared by clr_i, incremented on each DONE exit with err_o=1, saturating at 0xFFFF.
REQ-026 Without RS_SYNDROME_ERRCNT_EN, the err_cnt_o port and its logic SHALL be absent.

Structure
REQ-027 Shared package rs_pkg SHALL hold RS_N, RS_NSYM, GF_POLY=0x11D, gf8_t, the FSM state enum, and a gf_mul_alpha_pow(j) constant-multiply function.
REQ-028 Sub-module rs_synd_lane, with parameter J, SHALL implement one Horner accumulator; it is instantiated NSYM times by generate.
REQ-029 err_o SHALL be the registered OR-reduce of all S_j, computed on entry to DONE.

Verification
REQ-030 Send 200 bytes of 0x00 -> synd_o=0, err_o=0, synd_valid_o one cycle after the last byte.
REQ-031 Send 199 bytes of 0x00, then 0x01 (degree-0 error) -> every S_j=0x01, err_o=1.
REQ-032 Send 0x01 then 199 bytes of 0x00 -> S_0=0x01, S_j=alpha^(199j) against the golden model, err_o=1.
REQ-033 Pass a valid 200-byte codeword from the software RS(200,168) encoder model, with random cw_valid_i gaps -> all syndromes 0, err_o=0.
REQ-034 Hold synd_ready_i=0 for 50 cycles in DONE -> cw_ready_o=0 and synd_o unchanged throughout; on release, IDLE follows and the next codeword is correct.
REQ-035 Pulse clr_i after byte 100; also pulse rst_ni mid-codeword -> state returns to reset values, and the following full codeword yields correct syndromes; with the macro defined, err_cnt_o counts only the completed errored codewords.
